// File: rtl/tdm_demux.sv
// Time-division demultiplexer: steers a framed serial word stream into per-channel output slots.
// Optional double-buffered output (all slots update together) enabled by TDM_DEMUX_DBLBUF_EN.
module tdm_demux #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned SEL_W    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          d,
    input  logic                      d_valid,
    input  logic                      fs,
    output logic [CHANNELS*WIDTH-1:0] y,
    output logic [SEL_W-1:0]          s,
    output logic                      frame_valid,
    output logic                      locked,
    output logic                      sync_err,
    output logic [7:0]                err_cnt
);

    localparam logic [SEL_W-1:0] LastSlot = SEL_W'(CHANNELS - 1);

    typedef enum logic [0:0] {StHunt, StRun} state_e;

    state_e                    state_q, state_d;
    logic [SEL_W-1:0]          s_q, s_d;
    logic [CHANNELS*WIDTH-1:0] y_q, y_d;
    logic                      frame_valid_q, frame_valid_d;
    logic                      sync_err_q, sync_err_d;
    logic [7:0]                err_cnt_q, err_cnt_d;
    logic                      wr_en;
    logic [SEL_W-1:0]          wr_slot;
    logic                      err_inc;

`ifdef TDM_DEMUX_DBLBUF_EN
    logic [CHANNELS*WIDTH-1:0] shadow_q, shadow_d;
`endif

    always_comb begin
        state_d       = state_q;
        s_d           = s_q;
        y_d           = y_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        err_cnt_d     = err_cnt_q;
        wr_en         = 1'b0;
        wr_slot       = '0;
        err_inc       = 1'b0;

        if (d_valid) begin
            unique case (state_q)
                StHunt: begin
                    if (fs) begin
                        wr_en   = 1'b1;
                        s_d     = SEL_W'(1);
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (fs) begin
                        // Early fs abandons the partial frame and restarts at slot 0.
                        err_inc = (s_q != '0);
                        wr_en   = 1'b1;
                        s_d     = SEL_W'(1);
                    end else if (s_q == '0) begin
                        err_inc = 1'b1;
                        state_d = StHunt;
                    end else begin
                        wr_en   = 1'b1;
                        wr_slot = s_q;
                        if (s_q == LastSlot) begin
                            s_d           = '0;
                            frame_valid_d = 1'b1;
                        end else begin
                            s_d = s_q + 1'b1;
                        end
                    end
                end
            endcase
        end

        if (err_inc) begin
            sync_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end

`ifdef TDM_DEMUX_DBLBUF_EN
        shadow_d = shadow_q;
        if (wr_en) begin
            shadow_d[int'(wr_slot)*WIDTH +: WIDTH] = d;
        end
        if (frame_valid_d) begin
            y_d = shadow_d;
        end
`else
        if (wr_en) begin
            y_d[int'(wr_slot)*WIDTH +: WIDTH] = d;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StHunt;
            s_q           <= '0;
            y_q           <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            err_cnt_q     <= 8'd0;
`ifdef TDM_DEMUX_DBLBUF_EN
            shadow_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            s_q           <= s_d;
            y_q           <= y_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            err_cnt_q     <= err_cnt_d;
`ifdef TDM_DEMUX_DBLBUF_EN
            shadow_q      <= shadow_d;
`endif
        end
    end

    assign y           = y_q;
    assign s           = s_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign err_cnt     = err_cnt_q;
    assign locked      = (state_q == StRun);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux with WIDTH=8, CHANNELS=4, SEL_W=2.
module tb_tdm_demux;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  d = 8'h00;
    logic        d_valid = 1'b0;
    logic        fs = 1'b0;
    logic [31:0] y;
    logic [1:0]  s;
    logic        frame_valid;
    logic        locked;
    logic        sync_err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    tdm_demux #(
        .WIDTH   (8),
        .CHANNELS(4),
        .SEL_W   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .d_valid    (d_valid),
        .fs         (fs),
        .y          (y),
        .s          (s),
        .frame_valid(frame_valid),
        .locked     (locked),
        .sync_err   (sync_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // Apply one cycle of input, then let outputs settle 1 time unit past the edge.
    task automatic step(input logic v, input logic f, input logic [7:0] w);
        d_valid = v;
        fs      = f;
        d       = w;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b1, 1'b1, 8'hAA);
        step(1'b1, 1'b0, 8'hBB);
        rst = 1'b0;
        checks++;
        if ({y, s, frame_valid, locked, sync_err, err_cnt} !== 45'h0) begin
            errors++;
            $display("FAIL reset y=%h s=%0d fv=%b lk=%b se=%b ec=%0d exp all zero",
                     y, s, frame_valid, locked, sync_err, err_cnt);
        end
    endtask

    task automatic test_basic_frame();
        step(1'b1, 1'b1, 8'hA1);
        checks++;
        if (s !== 2'd1 || locked !== 1'b1 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_first s=%0d lk=%b fv=%b exp 1 1 0", s, locked, frame_valid);
        end
`ifndef TDM_DEMUX_DBLBUF_EN
        checks++;
        if (y !== 32'h0000_00A1) begin
            errors++;
            $display("FAIL basic_partial y=%h exp 000000a1", y);
        end
`endif
        step(1'b1, 1'b0, 8'hB2);
        step(1'b1, 1'b0, 8'hC3);
        checks++;
        if (s !== 2'd3 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_mid s=%0d fv=%b exp 3 0", s, frame_valid);
        end
        step(1'b1, 1'b0, 8'hD4);
        checks++;
        if (frame_valid !== 1'b1 || y !== 32'hD4C3B2A1 || s !== 2'd0 || locked !== 1'b1
            || err_cnt !== 8'd0 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_done fv=%b y=%h s=%0d lk=%b ec=%0d se=%b exp 1 d4c3b2a1 0 1 0 0",
                     frame_valid, y, s, locked, err_cnt, sync_err);
        end
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (frame_valid !== 1'b0 || y !== 32'hD4C3B2A1) begin
            errors++;
            $display("FAIL basic_pulse fv=%b y=%h exp 0 d4c3b2a1", frame_valid, y);
        end
    endtask

    task automatic test_hunt_discard();
        logic saw_err;
        saw_err = 1'b0;
        do_reset();
        step(1'b1, 1'b0, 8'h55);
        saw_err |= sync_err;
        step(1'b1, 1'b0, 8'h66);
        saw_err |= sync_err;
        checks++;
        if (locked !== 1'b0 || s !== 2'd0 || y !== 32'h0) begin
            errors++;
            $display("FAIL hunt_discard lk=%b s=%0d y=%h exp 0 0 0", locked, s, y);
        end
        step(1'b1, 1'b1, 8'hA1);
        saw_err |= sync_err;
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL hunt_lock lk=%b exp 1", locked);
        end
        step(1'b1, 1'b0, 8'hB2);
        saw_err |= sync_err;
        step(1'b1, 1'b0, 8'hC3);
        saw_err |= sync_err;
        step(1'b1, 1'b0, 8'hD4);
        saw_err |= sync_err;
        checks++;
        if (frame_valid !== 1'b1 || y !== 32'hD4C3B2A1 || saw_err !== 1'b0 || err_cnt !== 8'd0)
        begin
            errors++;
            $display("FAIL hunt_frame fv=%b y=%h se_seen=%b ec=%0d exp 1 d4c3b2a1 0 0",
                     frame_valid, y, saw_err, err_cnt);
        end
    endtask

    task automatic test_idle_gaps();
        logic [7:0] words [4];
        logic       bad_idle;
        words    = '{8'h1A, 8'h2B, 8'h3C, 8'h4D};
        bad_idle = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i == 0), words[i]);
            if (i < 3 && frame_valid !== 1'b0) bad_idle = 1'b1;
            if (i == 3) begin
                checks++;
                if (frame_valid !== 1'b1 || y !== 32'h4D3C2B1A) begin
                    errors++;
                    $display("FAIL idle_frame fv=%b y=%h exp 1 4d3c2b1a", frame_valid, y);
                end
            end
            step(1'b0, 1'b1, 8'hEE);
            if (frame_valid !== 1'b0 || sync_err !== 1'b0 || s !== 2'((i + 1) % 4))
                bad_idle = 1'b1;
            step(1'b0, 1'b0, 8'hFF);
            if (frame_valid !== 1'b0 || s !== 2'((i + 1) % 4)) bad_idle = 1'b1;
        end
        checks++;
        if (bad_idle !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold bad=%b exp 0 (s held, no pulses during idles)", bad_idle);
        end
    endtask

    task automatic test_early_fs();
        do_reset();
        step(1'b1, 1'b1, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b1, 8'h33);
        checks++;
        if (sync_err !== 1'b1 || err_cnt !== 8'd1 || s !== 2'd1 || locked !== 1'b1
            || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_fs se=%b ec=%0d s=%0d lk=%b fv=%b exp 1 1 1 1 0",
                     sync_err, err_cnt, s, locked, frame_valid);
        end
`ifdef TDM_DEMUX_DBLBUF_EN
        checks++;
        if (y !== 32'h0) begin
            errors++;
            $display("FAIL early_fs_hidden y=%h exp 00000000", y);
        end
`else
        checks++;
        if (y[7:0] !== 8'h33 || y[15:8] !== 8'h22) begin
            errors++;
            $display("FAIL early_fs_visible y=%h exp xxxx2233", y);
        end
`endif
        step(1'b1, 1'b0, 8'h44);
        checks++;
        if (sync_err !== 1'b0) begin
            errors++;
            $display("FAIL early_fs_pulse se=%b exp 0", sync_err);
        end
        step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'h66);
        checks++;
        if (frame_valid !== 1'b1 || sync_err !== 1'b0 || y !== 32'h66554433 || err_cnt !== 8'd1)
        begin
            errors++;
            $display("FAIL early_fs_frame fv=%b se=%b y=%h ec=%0d exp 1 0 66554433 1",
                     frame_valid, sync_err, y, err_cnt);
        end
    endtask

    task automatic test_missing_fs();
        int exp_cnt;
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            step(1'b1, 1'b1, 8'h01);
            step(1'b1, 1'b0, 8'h02);
            step(1'b1, 1'b0, 8'h03);
            step(1'b1, 1'b0, 8'h04);
            step(1'b1, 1'b0, 8'h77);
            exp_cnt = (i > 255) ? 255 : i;
            checks++;
            if (sync_err !== 1'b1 || locked !== 1'b0 || s !== 2'd0 || y !== 32'h04030201
                || err_cnt !== 8'(exp_cnt)) begin
                errors++;
                $display("FAIL missing_fs_%0d se=%b lk=%b s=%0d y=%h ec=%0d exp 1 0 0 04030201 %0d",
                         i, sync_err, locked, s, y, err_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        step(1'b1, 1'b1, 8'hA1);
        step(1'b1, 1'b0, 8'hB2);
        rst = 1'b1;
        step(1'b1, 1'b0, 8'hC3);
        rst = 1'b0;
        checks++;
        if (y !== 32'h0 || s !== 2'd0 || locked !== 1'b0 || err_cnt !== 8'd0
            || frame_valid !== 1'b0 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset y=%h s=%0d lk=%b ec=%0d fv=%b se=%b exp all zero",
                     y, s, locked, err_cnt, frame_valid, sync_err);
        end
        step(1'b1, 1'b1, 8'h10);
        step(1'b1, 1'b0, 8'h20);
        step(1'b1, 1'b0, 8'h30);
        step(1'b1, 1'b0, 8'h40);
        checks++;
        if (frame_valid !== 1'b1 || y !== 32'h40302010 || err_cnt !== 8'd0 || locked !== 1'b1)
        begin
            errors++;
            $display("FAIL midreset_frame fv=%b y=%h ec=%0d lk=%b exp 1 40302010 0 1",
                     frame_valid, y, err_cnt, locked);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_hunt_discard();
        test_idle_gaps();
        test_early_fs();
        test_missing_fs();
        test_mid_frame_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
